// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multicycle ARM controller.
// Contents: FSM state enum, ALUControl codes, Op encodings, data-processing
// cmd codes, ResultSrc/ALUSrcB select codes, and the cmd -> ALU op decode.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic [3:0] alu_ctl;
    logic       nowrite;
  } dp_dec_t;

  // Unsupported commands still run through the ALU as ADD, but their
  // result is discarded via nowrite.
  function automatic dp_dec_t decode_cmd(input logic [3:0] cmd);
    dp_dec_t d;
    d = '{alu_ctl: ALU_ADD, nowrite: 1'b1};
    case (cmd)
      CMD_ADD: d = '{alu_ctl: ALU_ADD, nowrite: 1'b0};
      CMD_SUB: d = '{alu_ctl: ALU_SUB, nowrite: 1'b0};
      CMD_AND: d = '{alu_ctl: ALU_AND, nowrite: 1'b0};
      CMD_ORR: d = '{alu_ctl: ALU_ORR, nowrite: 1'b0};
      CMD_CMP: d = '{alu_ctl: ALU_SUB, nowrite: 1'b1};
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle.
// Instr: IR bits [31:12]; ALUFlags: {N,Z,C,V} of the current ALU result.
// Remaining signals are per-cycle datapath selects and write strobes.
// master: the controller (drives controls); slave: the datapath.
interface multicycle_controller_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        IRWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic        AdrSrc;
  logic [1:0]  ResultSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ALUControl;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
  );
endinterface

// File: rtl/multicycle_controller_cond.sv
// cond_unit: stored NZCV flags, ARM condition table and cond_ex_q.
// Ports: clk, reset (sync, active-high), cond (Instr[31:28]), alu_flags,
// latch_cond (DECODE cycle), exec (EXECUTER/EXECUTEI cycle), s_bit,
// logic_op (AND/ORR: only NZ are updated), cond_ex_q (registered result).
module cond_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       latch_cond,
  input  logic       exec,
  input  logic       s_bit,
  input  logic       logic_op,
  output logic       cond_ex_q
);
  logic [3:0] flags_q;
  logic       n, z, c, v;
  logic       cond_ok;
  logic       nz_we, cv_we;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'h0: cond_ok = z;
      4'h1: cond_ok = ~z;
      4'h2: cond_ok = c;
      4'h3: cond_ok = ~c;
      4'h4: cond_ok = n;
      4'h5: cond_ok = ~n;
      4'h6: cond_ok = v;
      4'h7: cond_ok = ~v;
      4'h8: cond_ok = c & ~z;
      4'h9: cond_ok = ~c | z;
      4'hA: cond_ok = (n == v);
      4'hB: cond_ok = (n != v);
      4'hC: cond_ok = ~z & (n == v);
      4'hD: cond_ok = z | (n != v);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  assign nz_we = exec & cond_ex_q & s_bit;
  assign cv_we = nz_we & ~logic_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      if (latch_cond) cond_ex_q <= cond_ok;
      if (nz_we) flags_q[3:2] <= alu_flags[3:2];
      if (cv_we) flags_q[1:0] <= alu_flags[1:0];
    end
  end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARMv4 control FSM: sequences fetch/decode/execute over a
// shared memory, one ALU and one register file.
// Ports: clk, reset (sync, active-high), bus (multicycle_controller_if.master).
// MEM_WAIT (0..15) stretches FETCH and MEMREAD by that many cycles.
// Optional MULTICYCLE_CTRL_PERF_EN adds cycle_count / instr_count outputs.
//
// state      | meaning
// FETCH      | read instr at PC, PC+4 -> PC on last wait cycle
// DECODE     | register read, PC+8, latch condition result
// MEMADR     | address = Rn +/- imm
// MEMREAD    | load data from ALUOut address
// MEMWB      | write loaded data to Rd
// MEMWRITE   | store to ALUOut address
// EXECUTER   | data-processing, register operand
// EXECUTEI   | data-processing, immediate operand
// ALUWB      | write ALU result to Rd
// BRANCH     | PC <- PC+8+imm
module multicycle_controller
  import arm_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0]             cycle_count,
  output logic [31:0]             instr_count
`endif
);
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state, state_n;
  logic [3:0] wait_cnt;
  logic       wait_done;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       rd15;
  dp_dec_t    dp;
  logic       cond_ex_q;
  logic       unused_rn;

  logic       pc_w, ir_w, mem_w, reg_w, adr_src, alu_src_a;
  logic [1:0] result_src, alu_src_b;
  logic [3:0] alu_ctl;

  assign cond      = bus.Instr[19:16];
  assign op        = bus.Instr[15:14];
  assign funct     = bus.Instr[13:8];
  assign rd        = bus.Instr[3:0];
  assign unused_rn = ^bus.Instr[7:4];
  assign rd15      = (rd == 4'hF);
  assign dp        = decode_cmd(funct[4:1]);
  assign wait_done = (wait_cnt == WAIT_LAST);

  cond_unit u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond),
    .alu_flags (bus.ALUFlags),
    .latch_cond(state == S_DECODE),
    .exec      ((state == S_EXECUTER) || (state == S_EXECUTEI)),
    .s_bit     (funct[0]),
    .logic_op  ((funct[4:1] == CMD_AND) || (funct[4:1] == CMD_ORR)),
    .cond_ex_q (cond_ex_q)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  // Entry into FETCH/MEMREAD always comes from a state holding 0, so
  // clearing on exit is equivalent to loading 0 on entry.
  always_ff @(posedge clk) begin
    if (reset)
      wait_cnt <= 4'd0;
    else if (((state == S_FETCH) || (state == S_MEMREAD)) && !wait_done)
      wait_cnt <= wait_cnt + 4'd1;
    else
      wait_cnt <= 4'd0;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:    if (wait_done) state_n = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_MEM:  state_n = S_MEMADR;
          OP_DP:   state_n = funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_n = S_BRANCH;
          default: state_n = S_FETCH;
        endcase
      end
      S_MEMADR:   state_n = funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (wait_done) state_n = S_MEMWB;
      S_EXECUTER: state_n = S_ALUWB;
      S_EXECUTEI: state_n = S_ALUWB;
      default:    state_n = S_FETCH;
    endcase
  end

  always_comb begin
    pc_w       = 1'b0;
    ir_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RD2;
    alu_ctl    = ALU_ADD;
    case (state)
      S_FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        pc_w       = wait_done;
        ir_w       = wait_done;
      end
      S_DECODE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_FOUR;
      end
      S_MEMADR: begin
        alu_src_b = SRCB_IMM;
        alu_ctl   = funct[3] ? ALU_ADD : ALU_SUB;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = cond_ex_q;
        pc_w       = cond_ex_q & rd15;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = cond_ex_q;
      end
      S_EXECUTER: alu_ctl = dp.alu_ctl;
      S_EXECUTEI: begin
        alu_src_b = SRCB_IMM;
        alu_ctl   = dp.alu_ctl;
      end
      S_ALUWB: begin
        reg_w = cond_ex_q & ~dp.nowrite;
        pc_w  = cond_ex_q & ~dp.nowrite & rd15;
      end
      S_BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALU;
        pc_w       = cond_ex_q;
      end
      default: ;
    endcase
    // A reset cycle must never let a write land.
    if (reset) begin
      pc_w  = 1'b0;
      ir_w  = 1'b0;
      mem_w = 1'b0;
      reg_w = 1'b0;
    end
  end

  assign bus.PCWrite    = pc_w;
  assign bus.IRWrite    = ir_w;
  assign bus.MemWrite   = mem_w;
  assign bus.RegWrite   = reg_w;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_ctl;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};

`ifdef MULTICYCLE_CTRL_PERF_EN
  // Only terminal states ever move into FETCH; FETCH->FETCH is a wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= 32'd0;
      instr_count <= 32'd0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if ((state != S_FETCH) && (state_n == S_FETCH))
        instr_count <= instr_count + 32'd1;
    end
  end
`endif
endmodule
